apb_vend_cfg_master: RTL
========================

Name: apb_vend_cfg_master

Overview:
APB initiator that programs and reads the vending machine's per-item configuration words through the machine's APB responder. A host/supervisor issues single write, single read, or "restock-all" commands over a valid/ready command port. Restock-all walks every item with a read-modify-write that sets the stock field and leaves price and sold count untouched. Item word layout: [31:24] sold count, [23:16] stock, [15:0] price.

Parameters:
ITEMS, 64, number of item config words; restock walks indices 0..ITEMS-1
IDX_W, 6, item index width; paddr[IDX_W-1:0] carries the index
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort

Ports:
clk  in  1  single clock; APB and command logic both run on it
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE and not in reset
cmd_op  in  2  00 write, 01 read, 10 restock-all, 11 reserved
cmd_idx  in  IDX_W  item index for write/read
cmd_data  in  32  write word; restock uses [7:0] as new stock
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_data  out  32  read word / restock sold-out count / 0 for write
rsp_err  out  1  valid with rsp_valid: timeout or reserved op
busy  out  1  high from acceptance until the rsp_valid cycle inclusive
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  32  APB address = zero-extended item index
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready; tie high for zero-wait responder

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_data, rsp_err, busy, cmd_ready. FSM goes to IDLE. Counters clear.
- Reset mid-transfer: psel/penable drop at that edge. No rsp_valid for the aborted command.
- Acceptance: cmd_valid && cmd_ready at edge T. Command, index, and data are registered. cmd_valid while busy is ignored, not queued.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE -> SETUP on an accepted op 00, 01, or 10.
  - IDLE -> DONE on op 11. No APB activity; rsp_err=1; rsp_valid at T+1.
  - SETUP: psel=1, penable=0. paddr, pwrite, and pwdata are valid and held stable through ACCESS. SETUP -> ACCESS.
  - ACCESS: psel=1, penable=1. The transfer completes on the first edge with pready=1; prdata is sampled at that edge.
    - Single op: ACCESS -> DONE.
    - Restock: after a read completes, go to SETUP of the write to the same index. After a write completes, go to SETUP of the read of idx+1. After the write to ITEMS-1 completes, go to DONE.
    - No idle cycle between transfers.
  - DONE: rsp_valid=1 for one cycle, then IDLE; cmd_ready returns the next cycle.
- Timing with pready=1:
  - Single op: SETUP T+1, ACCESS T+2, rsp_valid T+3.
  - Restock: 4 cycles per item; rsp_valid at T+4*ITEMS+1 (T+257 for 64 items).
- Each pready-low cycle in ACCESS adds one cycle.
- Timeout: count ACCESS cycles with pready=0. At TIMEOUT consecutive waits, abort:
  - psel/penable drop at the next edge;
  - go to DONE with rsp_err=1 and rsp_data=0;
  - restock abandons the remaining items; items already written stay written.
- Restock write word = {old[31:24], cmd_data[7:0], old[15:0]}, where old = prdata captured from the read.
- Restock response: rsp_data[15:0] counts items whose old stock was 0. Width 16, saturating; rsp_data[31:16]=0.
- Read response: rsp_data = captured prdata. Write response: rsp_data=0.
- rsp_data and rsp_err hold their value until the next response. pwrite=0 and psel=0 whenever not in SETUP/ACCESS.

Test Plan:
1. Write, idx 5, data 0x0003_0028, pready=1 -> psel rises T+1, penable T+2, paddr=5, pwrite=1, pwdata=0x00030028; rsp_valid T+3, rsp_err=0; model word 5 = 0x00030028.
2. Read idx 5 after test 1 -> pwrite=0 during transfer; rsp_data=0x00030028 at T+3.
3. Read with pready low 3 ACCESS cycles -> penable high 4 cycles, rsp_valid T+6. Read with pready never asserted -> penable high 16 cycles, then psel=0, rsp_err=1, rsp_data=0.
4. Restock-all, cmd_data[7:0]=0x64; model items 3 and 10 stock 0, item 7 = 0x05020014 -> item 7 becomes 0x05640014, all items stock 0x64; rsp_data=2 at T+257; busy high T..T+257.
5. cmd_op=11 -> no psel; rsp_valid T+1 with rsp_err=1. Also cmd_valid pulsed during a busy restock -> cmd_ready=0, command dropped, restock result unchanged.
6. rst high for one cycle during restock at item 20 -> psel=0, busy=0 after that edge; no rsp_valid; items 21+ untouched; cmd_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/apb_vend_cfg_master_if.sv
// Command port plus APB initiator bus for the vending machine config master.
// The master modport is the initiator's view of the bus; the slave modport is the host/responder side.
interface apb_vend_cfg_master_if #(
  parameter int IDX_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [31:0]      cmd_data;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [31:0]      paddr;
  logic [31:0]      pwdata;
  logic [31:0]      prdata;
  logic             pready;

  modport master (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data, prdata, pready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_idx, cmd_data, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_vend_cfg_master.sv
// APB initiator for per-item vending config words: single read/write and restock-all
// (read-modify-write of the stock field over every item) with a pready timeout.
module apb_vend_cfg_master #(
  parameter int ITEMS   = 64,
  parameter int IDX_W   = 6,
  parameter int TIMEOUT = 16
) (
  input logic                       clk,
  input logic                       rst,
  apb_vend_cfg_master_if.master     bus
);
  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // SETUP  | APB setup phase, psel=1 penable=0
  // ACCESS | APB access phase, waiting for pready or timeout
  // DONE   | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t           state, state_n;
  logic [1:0]       op;
  logic [IDX_W-1:0] idx;
  logic [7:0]       stock;
  logic [31:0]      wdata;
  logic             wr_phase;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      so_cnt;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             psel, penable;
  logic             accept, timeout, last_item;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign timeout       = (state == ACCESS) && !bus.pready && (wait_cnt == '0);
  assign last_item     = (idx == IDX_W'(ITEMS - 1));

  assign bus.psel      = psel;
  assign bus.penable   = penable;
  assign bus.pwrite    = wr_phase && psel;
  assign bus.paddr     = 32'(idx);
  assign bus.pwdata    = wdata;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = (state != IDLE) || accept;

  always_comb begin
    state_n = state;
    psel    = 1'b0;
    penable = 1'b0;
    case (state)
      IDLE:   if (accept) state_n = (bus.cmd_op == OP_RSV) ? DONE : SETUP;
      SETUP: begin
        psel    = 1'b1;
        state_n = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (timeout)
          state_n = DONE;
        else if (bus.pready)
          state_n = (op == OP_RS && !(wr_phase && last_item)) ? SETUP : DONE;
      end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= OP_WR;
      idx      <= '0;
      stock    <= '0;
      wdata    <= '0;
      wr_phase <= 1'b0;
      wait_cnt <= '0;
      so_cnt   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          op       <= bus.cmd_op;
          idx      <= (bus.cmd_op == OP_RS) ? '0 : bus.cmd_idx;
          stock    <= bus.cmd_data[7:0];
          wdata    <= bus.cmd_data;
          wr_phase <= (bus.cmd_op == OP_WR);
          so_cnt   <= '0;
          if (bus.cmd_op == OP_RSV) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        SETUP: wait_cnt <= CNT_W'(TIMEOUT - 1);
        ACCESS: begin
          if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else if (!bus.pready) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            case (op)
              OP_WR: begin
                rsp_data <= '0;
                rsp_err  <= 1'b0;
              end
              OP_RD: begin
                rsp_data <= bus.prdata;
                rsp_err  <= 1'b0;
              end
              default: begin
                // Restock: read half captures the old word, write half advances the index.
                if (!wr_phase) begin
                  wdata    <= {bus.prdata[31:24], stock, bus.prdata[15:0]};
                  wr_phase <= 1'b1;
                  if (bus.prdata[23:16] == 8'h00 && so_cnt != 16'hFFFF)
                    so_cnt <= so_cnt + 16'd1;
                end else begin
                  wr_phase <= 1'b0;
                  if (last_item) begin
                    rsp_data <= {16'h0000, so_cnt};
                    rsp_err  <= 1'b0;
                  end else begin
                    idx <= idx + 1'b1;
                  end
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule
